reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 16, register count, 2..64.
- NUM_RD, 2, read port count, 1..4.
- ZERO_REG, 1, register 0 hardwired to zero when 1.
- AW is derived as clog2(NUM_REGS); it is not user-settable.

REQ-002 The block SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  reset rst, asynchronous, active-high.
- rd_addr  in  NUM_RD*AW  read addresses; port i uses slice [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  read data for port i.
- rd_busy  out  NUM_RD  addressed register has a pending write.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback register.
- wr_data  in  DATA_W  writeback data.
- rsv_valid  in  1  reservation request.
- rsv_addr  in  AW  register to mark pending.
- rsv_ready  out  1  reservation can be accepted this cycle.
- busy_vec  out  NUM_REGS  registered pending-write flags.

Function
REQ-003 Reads SHALL be combinational with zero latency and independent per port.
- Any two ports may use the same address.
REQ-004 Writeback bypass: when wr_en=1 and wr_addr equals a port's address, that port SHALL return wr_data in the same cycle with rd_busy=0.
REQ-005 Otherwise each port SHALL return the stored value, and rd_busy SHALL equal busy_vec[addr].
REQ-006 At the posedge with wr_en=1, the register SHALL take wr_data and its busy flag SHALL clear.
- Writes to non-busy registers are legal.
REQ-007 rsv_ready SHALL equal !busy_vec[rsv_addr] || (wr_en && wr_addr==rsv_addr).
- A busy register therefore stalls a second reservation (WAW protection).
REQ-008 A reservation SHALL be accepted on a clock edge where rsv_valid && rsv_ready, and busy_vec[rsv_addr] SHALL read 1 from the next cycle.
REQ-009 Simultaneous writeback and accepted reservation to the same register: data SHALL be written and busy SHALL end at 1 (reserve wins).
REQ-010 Simultaneous writeback and reservation to different registers SHALL both take effect in the same edge.
REQ-011 When ZERO_REG=1, register 0 SHALL behave as follows:
- It always reads 0 with rd_busy=0, and bypass is suppressed.
- Writes are ignored.
- Reservations see rsv_ready=1 and leave busy_vec[0]=0.
REQ-012 Addresses >= NUM_REGS SHALL behave as follows:
- Reads return 0 with rd_busy=0.
- Writes are ignored.
- Reservations see rsv_ready=1 with no effect.
REQ-013 rsv_valid=0 SHALL leave all busy flags unchanged except those cleared by writeback.

Reset
REQ-014 While rst=1, all registers SHALL be 0 and busy_vec SHALL be all 0, independent of clk.
- rd_data then shows 0 except for a bypassed write.
- rsv_ready then shows 1.
REQ-015 Reset asserted mid-operation SHALL discard all pending reservations and data.
- Writes and reservations presented while rst=1 SHALL have no effect.
REQ-016 The first edge after rst deasserts SHALL operate normally.

Structure
REQ-017 AW computation, parameter limits and a busy-vector type SHALL live in shared package reg_file_pkg.
REQ-018 Busy tracking (REQ-006 to REQ-011) SHALL be one sub-module, reg_scoreboard.
- The data array and read/bypass muxing SHALL stay in reg_file_sb.

Verification
REQ-019 Reset check: pulse rst mid-run -> all reads return 0x0000, busy_vec=0, rsv_ready=1 immediately, without a clock edge.
REQ-020 Write/read: write 0xBEEF to r5, then read r5 on both ports next cycle -> 0xBEEF on each, rd_busy=0.
REQ-021 Bypass: wr_en with r7=0x1234 while port 1 reads r7 -> rd_data1=0x1234 in the same cycle; port 0 reading r3 is unaffected.
REQ-022 Scoreboard: reserve r4 -> busy_vec[4]=1 next cycle.
- A second reserve of r4 sees rsv_ready=0.
- Writeback of r4 in the same cycle as that second reserve -> rsv_ready=1, and busy_vec[4] stays 1.
REQ-023 Zero register: write 0xFFFF to r0 and reserve r0 -> reads of r0 give 0x0000, busy_vec[0]=0.
REQ-024 Parameter sweep: NUM_REGS=12, NUM_RD=3.
- Read of address 13 -> 0.
- Write to address 13 ignored.
- All three ports read distinct registers concurrently and correctly.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared sizing, limits and busy-vector helpers for the register file.
// Exports addr_w(), reg_live(), onehot() and busy_vec_t.
package reg_file_pkg;

  localparam int MIN_REGS = 2;
  localparam int MAX_REGS = 64;
  localparam int MIN_RD   = 1;
  localparam int MAX_RD   = 4;

  typedef logic [MAX_REGS-1:0] busy_vec_t;

  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A register that really holds state: in range, and not a hardwired r0.
  function automatic logic reg_live(
    input int a,
    input int n,
    input bit z
  );
    return (a < n) && !(z && a == 0);
  endfunction

  function automatic busy_vec_t onehot(
    input int   idx,
    input logic en
  );
    busy_vec_t m;
    m = '0;
    if (en && idx >= 0 && idx < MAX_REGS)
      m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: reservations set, writebacks clear.
// Ports: clk, rst, wr_en/wr_addr, rsv_valid/rsv_addr, rsv_ready, busy_vec.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter bit ZERO_REG = 1'b1,
  parameter int AW       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ready,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_m;
  logic [NUM_REGS-1:0] clr_m;
  logic                wr_ok;
  logic                rsv_ok;
  logic                rsv_busy;
  logic                rsv_acc;

  assign wr_ok  = wr_en &&
                  reg_live(int'(wr_addr), NUM_REGS, ZERO_REG);
  assign rsv_ok = reg_live(int'(rsv_addr), NUM_REGS, ZERO_REG);

  always_comb begin
    rsv_busy = 1'b0;
    if (rsv_ok)
      rsv_busy = busy_q[rsv_addr];
  end

  // A writeback landing on the same edge frees the slot for a new owner.
  assign rsv_ready = !rsv_busy ||
                     (wr_en && wr_addr == rsv_addr);
  assign rsv_acc   = rsv_valid && rsv_ready && rsv_ok;

  assign set_m = NUM_REGS'(onehot(int'(rsv_addr), rsv_acc));
  assign clr_m = NUM_REGS'(onehot(int'(wr_addr), wr_ok));

  // Set after clear: a same-register reserve outlives the writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= (busy_q & ~clr_m) | set_m;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with writeback bypass and pending-write scoreboard.
// Ports: rd_addr/rd_data/rd_busy, wr_*, rsv_valid/rsv_addr/rsv_ready, busy_vec.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*addr_w(NUM_REGS)-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [addr_w(NUM_REGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_valid,
  input  logic [addr_w(NUM_REGS)-1:0] rsv_addr,
  output logic                     rsv_ready,
  output logic [NUM_REGS-1:0]      busy_vec
);

  localparam int AW = addr_w(NUM_REGS);

  if (NUM_REGS < MIN_REGS || NUM_REGS > MAX_REGS)
    $error("NUM_REGS out of range");
  if (NUM_RD < MIN_RD || NUM_RD > MAX_RD)
    $error("NUM_RD out of range");

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = wr_en &&
                 reg_live(int'(wr_addr), NUM_REGS, ZERO_REG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        mem[r] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .busy_vec  (busy_vec)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = rd_addr[i*AW +: AW];

    // Dead addresses (r0, out of range) never bypass and never stall.
    always_comb begin
      d = '0;
      b = 1'b0;
      if (reg_live(int'(a), NUM_REGS, ZERO_REG)) begin
        if (wr_en && wr_addr == a) begin
          d = wr_data;
        end else begin
          d = mem[a];
          b = busy_vec[a];
        end
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = d;
    assign rd_busy[i] = b;
  end

endmodule
